stateful_flow_engine: RTL
=========================

Name: stateful_flow_engine

Overview:
Parametrised per-flow stateful match/action stage for the P4 switch pipeline.
- Extracts a flow key and an event code from each packet word and reads that flow's current state.
- Uses {event, state} to index a programmable transition table yielding {upd_en, next_state, action}.
- Writes back next_state and emits the packet with action and states.
- Fixed 2-cycle latency, one packet per cycle, hazard forwarding, runtime config port, post-reset table init sequencer.

Parameters:
DATA_W, 512, packet word width
KEY_LSB, 0, bit offset of flow key in pkt_data_in
KEY_W, 4, flow key width; 2^KEY_W flows
EVT_LSB, 4, bit offset of event code
EVT_W, 2, event code width
STATE_W, 4, per-flow state width
ACTION_W, 16, action width
RESET_STATE, 0, state loaded into every flow by the init sweep
CNT_W, 32, statistics counter width
Derived localparams: TT_AW = EVT_W+STATE_W; ADDR_W = max(KEY_W, TT_AW); ENT_W = 1+STATE_W+ACTION_W.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pkt_vld_in  in  1  input word valid
pkt_data_in  in  DATA_W  input word
pkt_vld_out  out  1  output word valid
pkt_data_out  out  DATA_W  output word (unmodified copy)
action_out  out  ACTION_W  action from transition entry
state_out  out  STATE_W  flow state before transition
next_state_out  out  STATE_W  flow state after transition
cfg_wr_en  in  1  config write strobe
cfg_sel  in  1  0 = transition table, 1 = flow state table
cfg_addr  in  ADDR_W  table index; upper bits ignored for the narrower table
cfg_wdata  in  ENT_W  {upd_en, next_state, action}; flow write uses [STATE_W-1:0]
cfg_rdy  out  1  high once init sweep complete
pkt_cnt  out  CNT_W  packets emitted, saturating
upd_cnt  out  CNT_W  state updates performed, saturating
drop_cnt  out  CNT_W  packets ignored during init, saturating

Behaviour:
- Reset asserted (low): all outputs 0, counters 0, pipeline valids 0, FSM = INIT, sweep index 0. Assertion mid-operation aborts in-flight packets; no output is produced for them.
- Init FSM, states INIT and RUN:
  - INIT: each cycle, write transition entry[idx] = 0 (idx < 2^TT_AW) and flow state[idx] = RESET_STATE (idx < 2^KEY_W); idx++.
  - Leave INIT after idx = max(2^KEY_W, 2^TT_AW) - 1, then cfg_rdy = 1.
  - During INIT: cfg_wr_en is ignored; pkt_vld_in is ignored and increments drop_cnt.
- Pipeline in RUN:
  - Edge E0: S1 captures key, event, data.
  - Between E0 and E1: S1 reads the flow state with this priority: same-cycle cfg flow write to the same key > S2 forward (S2 valid, same key, S2 upd_en) > memory.
  - E1: S2 captures {key, cur_state, event, data}. S2 reads the transition entry combinationally at {event, cur_state}.
  - E2: all outputs registered. pkt_vld_out = 1, state_out = cur_state, next_state_out = upd_en ? entry.next_state : cur_state, action_out = entry.action. Flow state written iff upd_en.
- Latency: exactly 2 clocks from sample edge to pkt_vld_out. Back-to-back packets of the same flow must observe each other's updates.
- Collisions at the same edge:
  - cfg flow write and S2 writeback to the same key: cfg wins, writeback dropped, upd_cnt still increments.
  - cfg transition write to the entry S2 is reading: S2 uses the old entry.
- When pkt_vld_out is 0: action_out, state_out and next_state_out are 0; pkt_data_out holds its previous value.
- Counters saturate at all-ones and never wrap. pkt_cnt increments on each pkt_vld_out; upd_cnt increments on each upd_en.
- No backpressure; downstream must accept every cycle.

Decomposition:
- Package stateful_pkg: ENT_W/TT_AW/ADDR_W derivation functions, the transition-entry field offsets, and the cfg_sel encoding constants.
- One sub-module: flow_state_mem, holding the 2^KEY_W x STATE_W array. It has:
  - async read with the two-level forward mux;
  - one packet write port and one cfg write port, cfg having priority;
  - the init write port.
- The transition table, init FSM, pipeline and counters live in the top.

Test Plan:
- Init: release reset, hold pkt_vld_in = 1 → cfg_rdy rises after 64 cycles (defaults); drop_cnt = 64; no pkt_vld_out during init.
- Basic transition: cfg trans[{evt=1,st=0}] = {1,4'h3,16'h00ff}; packet key 5, evt 1 → 2 clocks later pkt_vld_out = 1, state_out = 0, next_state_out = 3, action_out = 00ff, data echoed; upd_cnt = 1.
- Forwarding: program 0→1→2 on evt 1, send three back-to-back key-7 evt-1 packets → state_out 0,1,2 and next_state_out 1,2,3 (program 2→3).
- No update: entry upd_en = 0, action 0200 → state_out = next_state_out = current value; a repeat packet sees the same state; upd_cnt unchanged.
- Collision: cfg flow write key 7 = 9 at the same edge as a key-7 writeback of 2 → next key-7 packet state_out = 9.
- Mid-run reset: assert reset with 2 packets in flight → outputs 0 immediately, no stale pkt_vld_out after release, counters 0, INIT re-runs.

Source files
------------

// File: rtl/stateful_flow_engine_pkg.sv
// Shared types and width helpers for the stateful flow engine: init FSM encoding,
// cfg_sel encoding and transition-entry layout {upd_en, next_state, action}.
package stateful_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_t;

    localparam logic CFG_SEL_TRANS = 1'b0;
    localparam logic CFG_SEL_FLOW  = 1'b1;

    function automatic int calc_tt_aw(input int evt_w, input int state_w);
        return evt_w + state_w;
    endfunction

    function automatic int calc_addr_w(input int key_w, input int tt_aw);
        return (key_w > tt_aw) ? key_w : tt_aw;
    endfunction

    function automatic int calc_ent_w(input int state_w, input int action_w);
        return 1 + state_w + action_w;
    endfunction

    // Entry layout, LSB first: action, next_state, upd_en.
    function automatic int ent_ns_lsb(input int action_w);
        return action_w;
    endfunction

    function automatic int ent_upd_bit(input int state_w, input int action_w);
        return state_w + action_w;
    endfunction

endpackage

// File: rtl/stateful_flow_engine_mem.sv
// Per-flow state array: async read with cfg > packet-writeback forwarding,
// one packet write port, one cfg write port (cfg wins on collision) and an init port.
module flow_state_mem
    import stateful_pkg::*;
#(
    parameter int KEY_W   = 4,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               init_we,
    input  logic [KEY_W-1:0]   init_addr,
    input  logic [STATE_W-1:0] init_wdata,
    input  logic               pkt_we,
    input  logic [KEY_W-1:0]   pkt_addr,
    input  logic [STATE_W-1:0] pkt_wdata,
    input  logic               cfg_we,
    input  logic [KEY_W-1:0]   cfg_addr,
    input  logic [STATE_W-1:0] cfg_wdata,
    input  logic [KEY_W-1:0]   rd_addr,
    output logic [STATE_W-1:0] rd_data
);

    logic [STATE_W-1:0] mem [2**KEY_W];
    logic               pkt_blocked;

    assign pkt_blocked = cfg_we && (cfg_addr == pkt_addr);

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_wdata;
        end else begin
            if (pkt_we && !pkt_blocked) begin
                mem[pkt_addr] <= pkt_wdata;
            end
            if (cfg_we) begin
                mem[cfg_addr] <= cfg_wdata;
            end
        end
    end

    // Reads see writes landing at the coming edge, so the reader never picks up a stale value.
    always_comb begin
        rd_data = mem[rd_addr];
        if (cfg_we && (cfg_addr == rd_addr)) begin
            rd_data = cfg_wdata;
        end else if (pkt_we && (pkt_addr == rd_addr)) begin
            rd_data = pkt_wdata;
        end
    end

endmodule

// File: rtl/stateful_flow_engine.sv
// Per-flow stateful match/action stage: 2-cycle pipeline, programmable transition
// table indexed by {event, state}, post-reset table init sweep and saturating stats.
module stateful_flow_engine
    import stateful_pkg::*;
#(
    parameter int DATA_W      = 512,
    parameter int KEY_LSB     = 0,
    parameter int KEY_W       = 4,
    parameter int EVT_LSB     = 4,
    parameter int EVT_W       = 2,
    parameter int STATE_W     = 4,
    parameter int ACTION_W    = 16,
    parameter int RESET_STATE = 0,
    parameter int CNT_W       = 32,
    localparam int TT_AW      = calc_tt_aw(EVT_W, STATE_W),
    localparam int ADDR_W     = calc_addr_w(KEY_W, TT_AW),
    localparam int ENT_W      = calc_ent_w(STATE_W, ACTION_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_vld_in,
    input  logic [DATA_W-1:0]   pkt_data_in,
    output logic                pkt_vld_out,
    output logic [DATA_W-1:0]   pkt_data_out,
    output logic [ACTION_W-1:0] action_out,
    output logic [STATE_W-1:0]  state_out,
    output logic [STATE_W-1:0]  next_state_out,
    input  logic                cfg_wr_en,
    input  logic                cfg_sel,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [ENT_W-1:0]    cfg_wdata,
    output logic                cfg_rdy,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]    upd_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    // Handshake: a word is taken on every edge where pkt_vld_in is high and the engine is
    // in RUN; there is no ready, and pkt_vld_out must be consumed on the cycle it is high.

    localparam int                 NS_LSB     = ent_ns_lsb(ACTION_W);
    localparam int                 UPD_BIT    = ent_upd_bit(STATE_W, ACTION_W);
    localparam logic [ADDR_W:0]    TT_DEPTH   = (ADDR_W+1)'(2**TT_AW);
    localparam logic [ADDR_W:0]    FLOW_DEPTH = (ADDR_W+1)'(2**KEY_W);

    init_state_t        state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               init_active;
    logic               run;
    logic               tt_init_hit, flow_init_hit;

    logic               cfg_trans_we, cfg_flow_we;

    logic               s1_vld;
    logic [KEY_W-1:0]   s1_key;
    logic [EVT_W-1:0]   s1_evt;
    logic [DATA_W-1:0]  s1_data;
    logic [STATE_W-1:0] s1_cur;

    logic               s2_vld;
    logic [KEY_W-1:0]   s2_key;
    logic [EVT_W-1:0]   s2_evt;
    logic [STATE_W-1:0] s2_cur;
    logic [DATA_W-1:0]  s2_data;

    logic [ENT_W-1:0]    tt_mem [2**TT_AW];
    logic [ENT_W-1:0]    ent;
    logic                ent_upd;
    logic [STATE_W-1:0]  ent_ns;
    logic [ACTION_W-1:0] ent_act;
    logic [STATE_W-1:0]  wb_state;
    logic                wb_we;

    // Init sweep FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_active = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_active = 1'b1;
                if (idx_q == '1) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    assign run           = (state_q == ST_RUN);
    assign cfg_rdy       = run;
    assign tt_init_hit   = ({1'b0, idx_q} < TT_DEPTH);
    assign flow_init_hit = ({1'b0, idx_q} < FLOW_DEPTH);

    assign cfg_trans_we = run && cfg_wr_en && (cfg_sel == CFG_SEL_TRANS);
    assign cfg_flow_we  = run && cfg_wr_en && (cfg_sel == CFG_SEL_FLOW);

    // Transition table
    always_ff @(posedge clk) begin
        if (init_active && tt_init_hit) begin
            tt_mem[idx_q[TT_AW-1:0]] <= '0;
        end else if (cfg_trans_we) begin
            tt_mem[cfg_addr[TT_AW-1:0]] <= cfg_wdata;
        end
    end

    // A cfg write at the same edge lands after this read, so S2 uses the old entry.
    assign ent      = tt_mem[{s2_evt, s2_cur}];
    assign ent_upd  = ent[UPD_BIT];
    assign ent_ns   = ent[NS_LSB +: STATE_W];
    assign ent_act  = ent[ACTION_W-1:0];
    assign wb_state = ent_upd ? ent_ns : s2_cur;
    assign wb_we    = s2_vld && ent_upd;

    flow_state_mem #(
        .KEY_W   (KEY_W),
        .STATE_W (STATE_W)
    ) u_flow_mem (
        .clk        (clk),
        .init_we    (init_active && flow_init_hit),
        .init_addr  (idx_q[KEY_W-1:0]),
        .init_wdata (STATE_W'(RESET_STATE)),
        .pkt_we     (wb_we),
        .pkt_addr   (s2_key),
        .pkt_wdata  (ent_ns),
        .cfg_we     (cfg_flow_we),
        .cfg_addr   (cfg_addr[KEY_W-1:0]),
        .cfg_wdata  (cfg_wdata[STATE_W-1:0]),
        .rd_addr    (s1_key),
        .rd_data    (s1_cur)
    );

    // S1: capture key, event and data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld  <= 1'b0;
            s1_key  <= '0;
            s1_evt  <= '0;
            s1_data <= '0;
        end else begin
            s1_vld <= run && pkt_vld_in;
            if (run && pkt_vld_in) begin
                s1_key  <= pkt_data_in[KEY_LSB +: KEY_W];
                s1_evt  <= pkt_data_in[EVT_LSB +: EVT_W];
                s1_data <= pkt_data_in;
            end
        end
    end

    // S2: capture the forwarded current state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_vld  <= 1'b0;
            s2_key  <= '0;
            s2_evt  <= '0;
            s2_cur  <= '0;
            s2_data <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_key  <= s1_key;
                s2_evt  <= s1_evt;
                s2_cur  <= s1_cur;
                s2_data <= s1_data;
            end
        end
    end

    // Output stage; pkt_data_out keeps its last value on idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_vld_out    <= 1'b0;
            pkt_data_out   <= '0;
            action_out     <= '0;
            state_out      <= '0;
            next_state_out <= '0;
        end else begin
            pkt_vld_out <= s2_vld;
            if (s2_vld) begin
                pkt_data_out   <= s2_data;
                action_out     <= ent_act;
                state_out      <= s2_cur;
                next_state_out <= wb_state;
            end else begin
                action_out     <= '0;
                state_out      <= '0;
                next_state_out <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt  <= '0;
            upd_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (s2_vld && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
            if (wb_we && (upd_cnt != '1)) begin
                upd_cnt <= upd_cnt + CNT_W'(1);
            end
            if (!run && pkt_vld_in && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule
